ifetch_line_responder: RTL and testbench
========================================

IFETCH_LINE_RESPONDER -- requirements
Module: ifetch_line_responder

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  input  1  synchronous active-low reset.
REQ-003 pc_index_valid  input  1  fetch request from instruction fetch unit.
REQ-004 pc_index  input  19  fetch index in 8-byte units; pc_index[18:3] selects the 64-byte line.
REQ-005 flush  input  1  abort the in-flight fetch (branch/interrupt redirect).
REQ-006 pc_index_ready  output  1  one-cycle pulse; pc_read_inst valid this cycle.
REQ-007 pc_read_inst  output  512  returned line; beat k in bits [64k+63:64k].
REQ-008 pc_operation_done  output  1  one-cycle pulse closing a completed fetch.
REQ-009 mem_rd_en  output  1  one-cycle read strobe to backing memory.
REQ-010 mem_rd_addr  output  19  {line, beat[2:0]}; valid when mem_rd_en=1.
REQ-011 mem_rd_data  input  64  read data; valid when mem_rd_valid=1.
REQ-012 mem_rd_valid  input  1  read return, ≥1 cycle after mem_rd_en, in order, one per strobe.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, RESP, DONE, DRAIN.
REQ-014 IDLE: pc_index_valid=1 and flush=0 SHALL latch pc_index[18:3] as line, clear beat counter, go REQ; otherwise stay.
REQ-015 pc_index_valid SHALL be sampled only in IDLE; valid still high in IDLE after DONE starts a new fetch.
REQ-016 REQ: mem_rd_en=1 for exactly one cycle, mem_rd_addr={line,beat}; go WAIT.
REQ-017 WAIT: on mem_rd_valid, write mem_rd_data into slot beat of pc_read_inst; beat==7 -> RESP, else beat+1 -> REQ.
REQ-018 Only one memory read SHALL be outstanding at any time.
REQ-019 RESP: pc_index_ready=1 one cycle, go DONE; DONE: pc_operation_done=1 one cycle, go IDLE.
REQ-020 pc_read_inst SHALL hold its value from RESP until a beat of a later fetch is written.
REQ-021 Flush in REQ: suppress mem_rd_en, go IDLE. Flush in WAIT: go DRAIN, or IDLE if mem_rd_valid is high that cycle (data discarded). Flush in RESP: suppress pc_index_ready, go IDLE. Flush in DONE: ignored.
REQ-022 DRAIN: discard next mem_rd_valid, then IDLE; flush in DRAIN has no further effect.
REQ-023 Aborted fetches SHALL produce neither pc_index_ready nor pc_operation_done.
REQ-024 mem_rd_valid outside WAIT/DRAIN SHALL be ignored.
REQ-025 Miss latency with memory latency L: pc_index_ready 1+8(1+L) cycles after the accepting edge; done one cycle later.

Reset
REQ-026 reset_n=0 at an edge SHALL force IDLE, beat=0, line=0, pc_read_inst=0, all outputs 0, line-buffer valid=0, regardless of state.
REQ-027 Reset mid-fetch SHALL drop the fetch; a stale mem_rd_valid after reset is ignored per REQ-024.

Configuration
REQ-028 Macro IFETCH_LINE_BUFFER_EN SHALL compile in a one-entry line buffer (16-bit tag + valid bit).
REQ-029 With it: tag/valid set on entering RESP of a full fetch; valid cleared on IDLE->REQ; IDLE request with valid=1 and tag match goes directly to RESP (ready 1 cycle after accept, no mem_rd_en).
REQ-030 Without it: no tag storage; every request follows REQ-014..REQ-025.

Verification
REQ-031 Reset, memory L=1, pc_index=0x00013 at cycle 0 -> mem_rd_addr 0x00010..0x00017 in order, pc_index_ready at cycle 17 with slot k=word k, done at cycle 18.
REQ-032 Memory L=3, line 0x40 -> ready at cycle 33, exactly 8 strobes, never two outstanding.
REQ-033 Flush during WAIT of beat 4, mem_rd_valid 2 cycles later -> DRAIN, return discarded, no ready/done, IDLE next; a new request then fetches cleanly.
REQ-034 Flush coinciding with RESP -> pc_index_ready stays 0, no done, IDLE next cycle.
REQ-035 IFETCH_LINE_BUFFER_EN: same line requested twice -> second ready 1 cycle after accept with zero strobes; a different line -> full miss, tag updated.
REQ-036 reset_n=0 in WAIT at beat 5, then request -> outputs 0 on the reset cycle, new fetch starts at beat 0, late return ignored.

Source files
------------

// File: rtl/ifetch_line_responder.sv
// Instruction-fetch line responder: gathers one 64-byte line as eight 8-byte reads.
// Define IFETCH_LINE_BUFFER_EN to add a one-entry line buffer that answers repeat requests for the last line without reading memory.
module ifetch_line_responder (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         pc_index_valid,
  input  logic [18:0]  pc_index,
  input  logic         flush,
  output logic         pc_index_ready,
  output logic [511:0] pc_read_inst,
  output logic         pc_operation_done,
  output logic         mem_rd_en,
  output logic [18:0]  mem_rd_addr,
  input  logic [63:0]  mem_rd_data,
  input  logic         mem_rd_valid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    line_q, line_d;
  logic [2:0]     beat_q, beat_d;
  logic [511:0]   inst_q;
  logic           wr_beat;
  logic           rd_en_q;
  logic           ready_q;
  logic           done_q;
  logic           hit;

  // The beat offset inside the line is irrelevant; whole lines are always fetched.
  logic           unused_pc_bits;
  assign unused_pc_bits = ^pc_index[2:0];

`ifdef IFETCH_LINE_BUFFER_EN
  logic           lb_valid_q;
  logic [15:0]    lb_tag_q;

  assign hit = lb_valid_q && (lb_tag_q == pc_index[18:3]);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= 16'd0;
    end else if (state_q == WAIT && state_d == RESP) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= line_q;
    end else if (state_q == IDLE && state_d == REQ) begin
      // The line register is about to be overwritten beat by beat.
      lb_valid_q <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    beat_d  = beat_q;
    wr_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_index_valid && !flush) begin
          line_d  = pc_index[18:3];
          beat_d  = 3'd0;
          state_d = hit ? RESP : REQ;
        end
      end
      REQ: begin
        state_d = flush ? IDLE : WAIT;
      end
      WAIT: begin
        if (flush) begin
          // A return arriving with the flush is simply dropped; otherwise it is still owed.
          state_d = mem_rd_valid ? IDLE : DRAIN;
        end else if (mem_rd_valid) begin
          wr_beat = 1'b1;
          if (beat_q == 3'd7) begin
            state_d = RESP;
          end else begin
            beat_d  = beat_q + 3'd1;
            state_d = REQ;
          end
        end
      end
      RESP: begin
        state_d = flush ? IDLE : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (mem_rd_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      line_q  <= 16'd0;
      beat_q  <= 3'd0;
      inst_q  <= 512'd0;
      rd_en_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      rd_en_q <= (state_d == REQ);
      ready_q <= (state_d == RESP);
      done_q  <= (state_d == DONE);
      if (wr_beat) begin
        inst_q[{beat_q, 6'd0} +: 64] <= mem_rd_data;
      end
    end
  end

  // Flush cancels a strobe or a ready pulse in the very cycle it is raised.
  assign mem_rd_en         = rd_en_q & ~flush;
  assign pc_index_ready    = ready_q & ~flush;
  assign pc_operation_done = done_q;
  assign mem_rd_addr       = {line_q, beat_q};
  assign pc_read_inst      = inst_q;

endmodule

// File: tb/tb_ifetch_line_responder.sv
// Directed bench for ifetch_line_responder with a latency-programmable in-order memory model.
module tb_ifetch_line_responder;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         pc_index_valid;
  logic [18:0]  pc_index;
  logic         flush;
  logic         pc_index_ready;
  logic [511:0] pc_read_inst;
  logic         pc_operation_done;
  logic         mem_rd_en;
  logic [18:0]  mem_rd_addr;
  logic [63:0]  mem_rd_data;
  logic         mem_rd_valid;

  ifetch_line_responder dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .pc_index_valid    (pc_index_valid),
    .pc_index          (pc_index),
    .flush             (flush),
    .pc_index_ready    (pc_index_ready),
    .pc_read_inst      (pc_read_inst),
    .pc_operation_done (pc_operation_done),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_valid      (mem_rd_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [18:0] addr;
    int          due;
  } pend_t;

  pend_t        pend[$];
  logic [18:0]  alog[$];
  int           lat = 1;
  int           outst = 0;
  int           max_outst = 0;
  int           strobes = 0;
  int           ready_cnt = 0;
  int           done_cnt = 0;
  int           ready_cyc = 0;
  int           done_cyc = 0;
  logic [511:0] cap_line = '0;
  int           n_chk = 0;
  int           n_pass = 0;

  function automatic logic [63:0] mdata(input logic [18:0] a);
    return {16'hC0DE, 13'd0, a, ~a[15:0]};
  endfunction

  function automatic logic [511:0] exp_line(input logic [15:0] ln);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[64*k +: 64] = mdata({ln, 3'(k)});
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory model and output monitor, sampled mid-cycle.
  always begin
    pend_t p;
    @(negedge clock);
    #2;
    mem_rd_valid = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = mdata(pend[0].addr);
      void'(pend.pop_front());
      outst--;
    end
    if (mem_rd_en) begin
      strobes++;
      alog.push_back(mem_rd_addr);
      p.addr = mem_rd_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
      outst++;
      if (outst > max_outst) max_outst = outst;
    end
    if (pc_index_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
      cap_line  = pc_read_inst;
    end
    if (pc_operation_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic start(input logic [15:0] ln, input logic [2:0] lo, output int t0);
    t0 = cyc;
    pc_index_valid = 1'b1;
    pc_index = {ln, lo};
    @(negedge clock);
    pc_index_valid = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [15:0] ln, input logic [2:0] lo,
                       input int exp_lat, input int exp_strb);
    int t0, s0, r0, d0;
    bit bad;
    s0 = strobes; r0 = ready_cnt; d0 = done_cnt;
    alog.delete();
    max_outst = 0;
    start(ln, lo, t0);
    for (int i = 0; i < 400 && ready_cnt == r0; i++) @(negedge clock);
    for (int i = 0; i < 10 && done_cnt == d0; i++) @(negedge clock);
    bad = 1'b0;
    for (int k = 0; k < alog.size(); k++) if (alog[k] !== {ln, 3'(k)}) bad = 1'b1;
    check_val({tag, "_lat"}, ready_cyc - t0, exp_lat);
    check_val({tag, "_done"}, done_cyc - ready_cyc, 1);
    check_val({tag, "_strb"}, strobes - s0, exp_strb);
    check_val({tag, "_line"}, cap_line, exp_line(ln));
    check_val({tag, "_addr"}, bad, 0);
    check_val({tag, "_outst"}, max_outst > 1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, s0, r0, d0, r1;
    logic [18:0] a_first, a_last;
    reset_n = 1'b0; pc_index_valid = 1'b0; pc_index = '0; flush = 1'b0;
    mem_rd_valid = 1'b0; mem_rd_data = '0;
    repeat (3) @(negedge clock);
    #3;
    check_val("rst_ctl", {mem_rd_en, pc_index_ready, pc_operation_done, mem_rd_addr}, 0);
    check_val("rst_inst", pc_read_inst, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Line 2, latency 1: addresses 0x10..0x17, ready 17 cycles after accept.
    lat = 1;
    fetch("l1", 16'h0002, 3'b011, 17, 8);
    a_first = (alog.size() > 0) ? alog[0] : '1;
    a_last  = (alog.size() > 7) ? alog[7] : '1;
    check_val("l1_first_addr", a_first, 19'h00010);
    check_val("l1_last_addr", a_last, 19'h00017);
    repeat (4) @(negedge clock);
    check_val("l1_hold", pc_read_inst, exp_line(16'h0002));

    lat = 3;
    fetch("l3", 16'h0040, 3'b000, 33, 8);
`ifdef IFETCH_LINE_BUFFER_EN
    fetch("hit40", 16'h0040, 3'b110, 1, 0);
    fetch("miss41", 16'h0041, 3'b001, 33, 8);
    fetch("hit41", 16'h0041, 3'b000, 1, 0);
`else
    fetch("re40", 16'h0040, 3'b110, 33, 8);
`endif

    // Flush while waiting on beat 4; its return lands two cycles later in DRAIN.
    lat = 3;
    s0 = strobes; r0 = ready_cnt; d0 = done_cnt;
    start(16'h0055, 3'b000, t0);
    wait_cyc(t0 + 18);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    wait_cyc(t0 + 21);
    check_val("wflush_strb", strobes - s0, 5);
    check_val("wflush_rdy", ready_cnt - r0, 0);
    check_val("wflush_done", done_cnt - d0, 0);
    check_val("wflush_drained", outst, 0);
    fetch("after_drain", 16'h0066, 3'b010, 33, 8);

    // Flush in RESP: no ready, no done, IDLE in the next cycle.
    lat = 1;
    r0 = ready_cnt; d0 = done_cnt;
    start(16'h0077, 3'b000, t0);
    wait_cyc(t0 + 17);
    flush = 1'b1;
    #3;
    check_val("rflush_rdy_pin", pc_index_ready, 0);
    @(negedge clock);
    flush = 1'b0;
    check_val("rflush_rdy", ready_cnt - r0, 0);
    check_val("rflush_done", done_cnt - d0, 0);
    fetch("after_rflush", 16'h0078, 3'b000, 17, 8);

    // Flush in REQ: the strobe is suppressed.
    s0 = strobes;
    start(16'h0011, 3'b000, t0);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check_val("qflush_strb", strobes - s0, 0);
    fetch("after_qflush", 16'h0012, 3'b000, 17, 8);

    // Flush in WAIT with the return in the same cycle: straight to IDLE.
    s0 = strobes; r0 = ready_cnt; d0 = done_cnt;
    start(16'h0021, 3'b000, t0);
    wait_cyc(t0 + 2);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check_val("vflush_strb", strobes - s0, 1);
    fetch("after_vflush", 16'h0022, 3'b000, 17, 8);
    check_val("vflush_rdy", ready_cnt - r0, 1);
    check_val("vflush_done", done_cnt - d0, 1);

    // Flush in DONE is ignored.
    r0 = ready_cnt; d0 = done_cnt;
    start(16'h0031, 3'b000, t0);
    wait_cyc(t0 + 18);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    @(negedge clock);
    check_val("dflush_done", done_cnt - d0, 1);
    check_val("dflush_done_cyc", done_cyc - t0, 18);
    check_val("dflush_rdy", ready_cnt - r0, 1);

    // Request held high across DONE starts the next fetch from IDLE.
    s0 = strobes; r0 = ready_cnt;
    t0 = cyc;
    pc_index = {16'h0051, 3'b000};
    pc_index_valid = 1'b1;
    @(negedge clock);
    pc_index = {16'h0052, 3'b000};
    for (int i = 0; i < 100 && ready_cnt == r0; i++) @(negedge clock);
    r1 = ready_cyc;
    check_val("held_first_lat", r1 - t0, 17);
    check_val("held_first_line", cap_line, exp_line(16'h0051));
    wait_cyc(t0 + 20);
    pc_index_valid = 1'b0;
    for (int i = 0; i < 100 && ready_cnt < r0 + 2; i++) @(negedge clock);
    check_val("held_second_gap", ready_cyc - r1, 19);
    check_val("held_second_line", cap_line, exp_line(16'h0052));
    check_val("held_strb", strobes - s0, 16);
    wait_cyc(t0 + 40);

    // Reset while waiting on beat 5; the late return arrives in IDLE.
    lat = 3;
    start(16'h0061, 3'b000, t0);
    wait_cyc(t0 + 22);
    reset_n = 1'b0;
    @(negedge clock);
    #3;
    check_val("rstw_ctl", {mem_rd_en, pc_index_ready, pc_operation_done, mem_rd_addr}, 0);
    check_val("rstw_inst", pc_read_inst, 0);
    reset_n = 1'b1;
    wait_cyc(t0 + 26);
    check_val("rstw_stale_gone", outst, 0);
    fetch("after_rst", 16'h0062, 3'b111, 33, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
